bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble).
//   It is the producer side of the seg7 path: it turns a raw binary count into
//   packed BCD digits, and each 4-bit digit feeds one seg7 decoder instance.
//   It processes one input bit per clock and uses a start/busy/done handshake.
// PARAMETERS
//   BIN_W   8  width of the binary input; also the conversion length in cycles
//   DIGITS  3  number of BCD digits produced (bcd width = 4*DIGITS)
// PORTS
//   clk    in   1         rising-edge clock
//   rst    in   1         asynchronous reset, active-high
//   start  in   1         request a conversion; sampled only when busy=0
//   bin    in   BIN_W     value to convert; captured on the accepting edge only
//   busy   out  1         conversion in progress
//   done   out  1         one-cycle pulse: bcd/ovf hold a new result
//   bcd    out  4*DIGITS  packed result; digit k at bcd[4k+3:4k], k=0 is units
//   ovf    out  1         result truncated; valid while done=1, held until next done
//   blank  out  DIGITS    leading-zero mask (present only with the macro; see CONFIGURATION)
// BEHAVIOUR
//   Reset (async): state=IDLE, busy=0, done=0, bcd=0, ovf=0, blank=0.
//     Reset asserted mid-conversion aborts it, and no done pulse is issued.
//   FSM IDLE:
//     start=1 at edge E0: latch bin into shift reg sh, clear accumulator acc,
//     cnt=BIN_W, go to SHIFT, busy=1.
//   FSM SHIFT, each edge:
//     every acc digit >=5 gets +3 (all digits in parallel, same cycle);
//     then {acc,sh} shifts left 1; cnt decrements.
//     A 1 shifted out of the top digit sets the internal ovf flag (sticky per conversion).
//     When cnt reaches 0 on this edge: load bcd and ovf regs, done=1, busy=0, go to IDLE.
//   Latency: done is high in the cycle after edge E0+BIN_W (8 cycles at default).
//     busy is high for exactly BIN_W cycles.
//   done is high for exactly one cycle; bcd/ovf/blank then hold until the next done.
//   start while busy=1: ignored, with no queueing; bin changes while busy have no effect.
//   start asserted in the same cycle as done=1: accepted (busy=0 then).
//     Back-to-back throughput is one result per BIN_W+1 cycles... note: the next
//     done follows BIN_W edges after that start edge.
//   Overflow:
//     if bin > 10^DIGITS-1, bcd = bin mod 10^DIGITS (upper digits dropped) and ovf=1.
//     Otherwise ovf=0.
//   Digits are always valid BCD (0-9); 4'hA-4'hF never appear on bcd.
//   Width rule: acc is exactly 4*DIGITS bits; cnt is $clog2(BIN_W+1) bits.
// CONFIGURATION
//   BIN2BCD_BLANK_EN defined:
//     adds output blank[DIGITS-1:0], registered and loaded together with bcd.
//     blank[k]=1 iff digit k and all higher digits are 0, for k>=1.
//     blank[0] is always 0 (a value of 0 shows a single "0").
//   BIN2BCD_BLANK_EN undefined:
//     the blank port and its logic are absent; all other behaviour is identical.
// TESTING  (BIN_W=8, DIGITS=3 unless noted; check done exactly 8 cycles after start)
//   rst=1 mid-SHIFT -> busy=0, done=0, bcd=12'h000 immediately; no done pulse afterwards.
//   bin=0 start -> bcd=12'h000, ovf=0; bin=255 -> bcd=12'h255, ovf=0.
//   Sweep bin 0..255 -> each bcd equals the decimal digits of bin; busy=1 for exactly 8 cycles.
//   start held again on the done cycle with bin=99 -> accepted; next bcd=12'h099;
//     with macro, blank=3'b100.
//   start pulsed at cycle 3 of a busy conversion of 17 with bin=200 -> ignored;
//     result 12'h017; done pulses once.
//   DIGITS=2, bin=255 -> bcd=8'h55, ovf=1; then bin=42 -> bcd=8'h42, ovf=0.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle for bin2bcd_seq.
// The blank field and modport members exist only when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (output start, bin, input busy, done, bcd, ovf, blank);
  modport slave  (input start, bin, output busy, done, bcd, ovf, blank);
`else
  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Optional leading-zero mask output enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_seq_if.slave bus
);
  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_reg, state_next;
  logic [BIN_W-1:0]  sh_reg;
  logic [AW-1:0]     acc_reg;
  logic [CW-1:0]     cnt_reg;
  logic              ovf_acc_reg;
  logic [AW-1:0]     bcd_reg;
  logic              ovf_reg;
  logic              done_reg;

  logic [AW-1:0]     adj;
  logic [AW-1:0]     acc_shift;
  logic              accept;
  logic              last;
  logic              ovf_next;

  assign accept = (state_reg == IDLE) && bus.start;
  assign last   = (state_reg == SHIFT) && (cnt_reg == CW'(1));

  // All digits are corrected in parallel before the shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ? acc_reg[4*gi +: 4] + 4'd3
                                                          : acc_reg[4*gi +: 4];
  end

  assign acc_shift = {adj[AW-2:0], sh_reg[BIN_W-1]};
  assign ovf_next  = ovf_acc_reg | adj[AW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == CW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_reg == SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_reg      <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      ovf_acc_reg <= 1'b0;
      bcd_reg     <= '0;
      ovf_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        sh_reg      <= bus.bin;
        acc_reg     <= '0;
        cnt_reg     <= CW'(BIN_W);
        ovf_acc_reg <= 1'b0;
      end else if (state_reg == SHIFT) begin
        sh_reg      <= sh_reg << 1;
        acc_reg     <= acc_shift;
        cnt_reg     <= cnt_reg - CW'(1);
        ovf_acc_reg <= ovf_next;
        if (last) begin
          bcd_reg  <= acc_shift;
          ovf_reg  <= ovf_next;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.done = done_reg;
  assign bus.bcd  = bcd_reg;
  assign bus.ovf  = ovf_reg;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_reg, blank_next;

  // Units digit is never blanked so that zero still shows "0".
  assign blank_next[0] = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
    assign blank_next[gi] = ~|acc_shift[AW-1:4*gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       blank_reg <= '0;
    else if (last) blank_reg <= blank_next;
  end

  assign bus.blank = blank_reg;
`endif
endmodule
